// File: rtl/param_skid_fifo.sv
// Parametrised valid/ready elastic buffer: circular register array with registered
// handshake flags, occupancy count, almost-full flag and synchronous flush.
module param_skid_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AF_TH  = DEPTH - 1,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_flush,
    output logic              o_data_in_ready,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_out_ready,
    output logic              o_data_out_valid,
    output logic [DATA_W-1:0] o_data_out,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_almost_full
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(AF_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_next;
    logic              push;
    logic              pop;

    assign push       = data_in_valid & o_data_in_ready;
    assign pop        = o_data_out_valid & data_out_ready;
    assign o_data_out = mem[rd_ptr];

    // o_count doubles as the occupancy register; flags are precomputed from cnt_next
    always_comb begin
        cnt_next = o_count;
        if (i_flush)
            cnt_next = '0;
        else if (push && !pop)
            cnt_next = o_count + CNT_W'(1);
        else if (pop && !push)
            cnt_next = o_count - CNT_W'(1);
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[PTR_W'(i)] <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_count          <= '0;
            o_data_in_ready  <= 1'b1;
            o_data_out_valid <= 1'b0;
            o_almost_full    <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= data_in;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count          <= cnt_next;
            o_data_in_ready  <= (cnt_next < DEPTH_C);
            o_data_out_valid <= (cnt_next != '0);
            o_almost_full    <= (cnt_next >= AF_TH_C);
        end
    end

endmodule

// File: tb/tb_param_skid_fifo.sv
// Scoreboard bench for param_skid_fifo over three parameter sets
// (4/3/24-bit, 2/1/24-bit, 16/12/8-bit) running concurrently.
module tb_param_skid_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done   = 0;

    task automatic check(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int D  = (g == 0) ? 4 : (g == 1) ? 2 : 16;
        localparam int AF = (g == 0) ? 3 : (g == 1) ? 1 : 12;
        localparam int DW = (g == 2) ? 8 : 24;
        localparam int CW = $clog2(D + 1);

        logic          rst;
        logic          flush;
        logic          in_valid;
        logic          in_ready;
        logic [DW-1:0] din;
        logic          out_ready;
        logic          out_valid;
        logic [DW-1:0] dout;
        logic [CW-1:0] cnt;
        logic          af;
        logic [DW-1:0] exp_q[$];

        param_skid_fifo #(.DATA_W(DW), .DEPTH(D), .AF_TH(AF)) dut (
            .s_clk           (clk),
            .s_rst           (rst),
            .i_flush         (flush),
            .o_data_in_ready (in_ready),
            .data_in_valid   (in_valid),
            .data_in         (din),
            .data_out_ready  (out_ready),
            .o_data_out_valid(out_valid),
            .o_data_out      (dout),
            .o_count         (cnt),
            .o_almost_full   (af)
        );

        // Monitor: state checks against queue occupancy, then pop/compare and record pushes
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                check(g, "count", 64'(cnt), 64'(exp_q.size()));
                check(g, "out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                check(g, "in_ready", 64'(in_ready), 64'(exp_q.size() < D));
                check(g, "almost_full", 64'(af), 64'(exp_q.size() >= AF));
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0)
                            check(g, "pop_when_empty", 64'(out_valid), 64'(0));
                        else
                            check(g, "data_order", 64'(dout), 64'(exp_q.pop_front()));
                    end
                    if (in_valid && in_ready)
                        exp_q.push_back(din);
                end
            end
        end

        initial begin : stim
            logic acc;
            int   acc_n;
            int   sent;
            int   guard;
            int   exp_n;
            int   n_store;

            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0; acc = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            check(g, "rst_ready", 64'(in_ready), 64'(1));
            check(g, "rst_valid", 64'(out_valid), 64'(0));
            check(g, "rst_count", 64'(cnt), 64'(0));
            check(g, "rst_af", 64'(af), 64'(0));
            check(g, "rst_data", 64'(dout), 64'(0));

            // Streaming: one word per cycle with the sink always ready
            out_ready = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                in_valid = 1'b1;
                din = DW'(i);
                @(posedge clk); #1;
                check(g, "stream_cnt_le1", 64'(cnt <= CW'(1)), 64'(1));
                check(g, "stream_data", 64'(dout), 64'(i));
            end
            in_valid = 1'b0;
            repeat (3) @(posedge clk); #1;

            // Fill under backpressure then drain
            out_ready = 1'b0;
            acc_n = 0;
            for (int i = 0; i < D + 2; i++) begin
                in_valid = 1'b1;
                if (i < D) din = DW'(24'hA00000 + i);
                @(negedge clk); acc = in_ready;
                @(posedge clk); #1;
                if (acc) acc_n++;
                exp_n = (i + 1 < D) ? i + 1 : D;
                check(g, "fill_count", 64'(cnt), 64'(exp_n));
                check(g, "fill_af", 64'(af), 64'(exp_n >= AF));
                check(g, "fill_ready", 64'(in_ready), 64'(exp_n < D));
            end
            check(g, "fill_accepted", 64'(acc_n), 64'(D));
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check(g, "ready_after_pop", 64'(in_ready), 64'(1));
            check(g, "count_after_pop", 64'(cnt), 64'(D - 1));
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(posedge clk); #1; guard++;
            end
            check(g, "drain1_left", 64'(exp_q.size()), 64'(0));

            // Random valid/ready, 1000 words across many pointer wraps
            sent = 0; guard = 0; acc = 1'b0;
            while (sent < 1000 && guard < 20000) begin
                if (!in_valid || acc) begin
                    in_valid = 1'($urandom_range(0, 1));
                    din = DW'($urandom);
                end
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk); acc = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc) sent++;
                guard++;
            end
            check(g, "rand_sent", 64'(sent), 64'(1000));
            in_valid = 1'b0;
            out_ready = 1'b1;
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(posedge clk); #1; guard++;
            end
            check(g, "drain2_left", 64'(exp_q.size()), 64'(0));

            // Flush with stored words and a concurrent push
            n_store = (D < 3) ? D : 3;
            out_ready = 1'b0;
            for (int i = 0; i < n_store; i++) begin
                in_valid = 1'b1;
                din = DW'(24'hC00000 + i);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            din = DW'(24'hBEEF00);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            in_valid = 1'b0;
            check(g, "flush_valid", 64'(out_valid), 64'(0));
            check(g, "flush_count", 64'(cnt), 64'(0));
            check(g, "flush_ready", 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            din = DW'(24'h123456);
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check(g, "post_flush_valid", 64'(out_valid), 64'(1));
            check(g, "post_flush_data", 64'(dout), 64'(DW'(24'h123456)));
            check(g, "post_flush_count", 64'(cnt), 64'(1));
            @(posedge clk); #1;
            check(g, "post_flush_alone", 64'(out_valid), 64'(0));

            // Asynchronous reset mid-cycle with words stored
            out_ready = 1'b0;
            in_valid = 1'b1;
            din = DW'(24'h5A5A5A);
            @(posedge clk); #1;
            din = DW'(24'h3C3C3C);
            @(posedge clk); #1;
            in_valid = 1'b0;
            #2 rst = 1'b1;
            #1;
            check(g, "arst_valid", 64'(out_valid), 64'(0));
            check(g, "arst_ready", 64'(in_ready), 64'(1));
            check(g, "arst_count", 64'(cnt), 64'(0));
            check(g, "arst_af", 64'(af), 64'(0));
            check(g, "arst_data", 64'(dout), 64'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk); #1;
            check(g, "arst_no_output", 64'(out_valid), 64'(0));
            done++;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && done < 3; t++)
            @(posedge clk);
        check(-1, "all_configs_done", 64'(done), 64'(3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_skid_fifo.md
# param_skid_fifo

Parametrised elastic buffer for valid/ready streams. It replaces the fixed single-entry skid stage on the RAM-side data paths (weight, spike and activation streams feeding the PE arrays). The data width and depth are configurable, and every handshake output is registered, so no combinational path runs from input to output. It adds an occupancy count, an almost-full flag and a synchronous flush for layer and time-step boundaries.

## Interface
Parameters:
- DATA_W, default 24 (`QUAN_BITS*3`): payload width in bits.
- DEPTH, default 4: number of storage entries. Must be a power of two and at least 2.
- AF_TH, default DEPTH-1: occupancy at or above which o_almost_full asserts. Legal range 1..DEPTH.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- s_clk, input, 1: the single clock. Everything is on its rising edge.
- s_rst, input, 1: asynchronous, active-high reset.
- i_flush, input, 1: synchronous clear. Discards all stored entries.
- o_data_in_ready, output, 1: the buffer can accept a word. Registered.
- data_in_valid, input, 1: the upstream word is valid.
- data_in, input, DATA_W: upstream payload.
- data_out_ready, input, 1: downstream can accept a word.
- o_data_out_valid, output, 1: the output word is valid. Registered.
- o_data_out, output, DATA_W: output payload. Read from the storage entry at the read pointer.
- o_count, output, CNT_W: current occupancy, 0..DEPTH. Registered.
- o_almost_full, output, 1: asserted when o_count >= AF_TH. Registered.

## Operation
- Storage is a circular register array of DEPTH entries.
  - Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy cnt runs 0..DEPTH. Full and empty are decided from cnt, not from pointer compare.
- push = data_in_valid & o_data_in_ready. On push: mem[wr_ptr] <= data_in and wr_ptr increments.
- pop = o_data_out_valid & data_out_ready. On pop: rd_ptr increments.
- Occupancy update:
  - cnt_next = cnt + push - pop.
  - Simultaneous push and pop leaves cnt unchanged; both pointers advance.
- Registered flags, all derived from cnt_next:
  - o_data_in_ready <= (cnt_next < DEPTH)
  - o_data_out_valid <= (cnt_next != 0)
  - o_almost_full <= (cnt_next >= AF_TH)
  - o_count <= cnt_next
- Combinational paths: o_data_out is a mux of registers selected by rd_ptr. No input port combinationally drives o_data_in_ready, o_data_out_valid or o_data_out.
- Flush: i_flush high at an edge forces cnt, wr_ptr and rd_ptr to 0.
  - A push or pop in the same cycle is ignored, and the data is discarded.
  - The next cycle shows o_data_out_valid=0, o_data_in_ready=1, o_count=0.
  - mem contents are not cleared.
- Reset (asynchronous):
  - cnt=0, wr_ptr=0, rd_ptr=0.
  - o_data_in_ready=1, o_data_out_valid=0, o_count=0, o_almost_full=0.
  - mem entries are cleared to 0, so o_data_out=0.
  - Reset mid-transfer drops all contents with no further output.
- Protocol violations are not defended against:
  - data_in must hold stable while data_in_valid is high and ready is low.
  - The upstream must not drop valid without a handshake.

## Timing
- Latency: a word pushed at edge N, into an empty buffer, is on o_data_out with o_data_out_valid=1 after edge N.
  - That is one cycle, first-word-fall-through from storage.
- Throughput: one word per cycle sustained when data_out_ready is held high. Any DEPTH >= 2 sustains this.
- Full boundary:
  - With cnt=DEPTH, ready is 0, so no push can occur.
  - A pop at edge N makes ready=1 after edge N. The next push is possible at edge N+1, a one-cycle bubble.
  - With DEPTH >= 2 this bubble never appears in steady streaming.
- Empty boundary: valid is 0, so no pop can occur. A push at edge N gives valid=1 after edge N.
- Backpressure: with data_out_ready held 0, exactly DEPTH words are accepted, and ready falls after the DEPTH-th push edge.
- Ordering: strict FIFO order. Pointer wrap must not reorder words or lose them.

## Test plan
- Reset then idle:
  - Outputs are o_data_in_ready=1, valid=0, o_count=0, o_almost_full=0, o_data_out=0.
  - Assert s_rst asynchronously mid-cycle. Outputs must clear before the next edge.
- Streaming: DEPTH=4, push 0x000001..0x000010 every cycle with data_out_ready=1.
  - Output order is 0x000001..0x000010, one per cycle, after 1 cycle latency.
  - o_count stays at or below 1.
- Fill and drain: data_out_ready=0, push 0xA00000+i.
  - Exactly 4 accepted. ready=0 and o_count=4 after the 4th edge. o_almost_full=1 once count reaches 3.
  - Then data_out_ready=1: 0xA00000..0xA00003 drain in order.
  - ready=1 one cycle after the first pop.
- Wrap with random stalls: 1000 words, random valid and ready at 50%.
  - The scoreboard sees in-order, lossless output.
  - o_count always equals pushes minus pops.
- Flush: with 3 stored words, assert i_flush together with a push of 0xBEEF00.
  - Next cycle: valid=0, count=0, ready=1.
  - A later push of 0x123456 appears alone at the output.
- Parameter sweep: DEPTH=2, AF_TH=1 and DEPTH=16, AF_TH=12, DATA_W=8.
  - Rerun scenarios 2–4 for each. Full and almost-full thresholds hit at exactly 2/1 and 16/12.
